// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: free-running h/v counters, registered
// framebuffer fetch coordinates, and sync/DE delayed LOOKAHEAD clocks behind the fetch stage.

module vga_timing_gen_param_check #(
  parameter int H_TOTAL     = 1586,
  parameter int H_SYNC      = 190,
  parameter int H_ACT_START = 285,
  parameter int H_ACTIVE    = 1270,
  parameter int V_TOTAL     = 526,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOOKAHEAD   = 2
) ();

  if (H_SYNC >= H_ACT_START) begin : g_err_hsync
    $error("vga_timing_gen: H_SYNC must be smaller than H_ACT_START");
  end

  if (H_ACT_START + H_ACTIVE > H_TOTAL) begin : g_err_hact
    $error("vga_timing_gen: horizontal active area exceeds H_TOTAL");
  end

  if (V_ACT_START + V_ACTIVE > V_TOTAL) begin : g_err_vact
    $error("vga_timing_gen: vertical active area exceeds V_TOTAL");
  end

  if (LOOKAHEAD > 7 || LOOKAHEAD < 0) begin : g_err_look
    $error("vga_timing_gen: LOOKAHEAD must be in 0..7");
  end

endmodule

module vga_timing_gen #(
  parameter int H_TOTAL      = 1586,
  parameter int H_SYNC       = 190,
  parameter int H_ACT_START  = 285,
  parameter int H_ACTIVE     = 1270,
  parameter int V_TOTAL      = 526,
  parameter int V_SYNC       = 2,
  parameter int V_ACT_START  = 35,
  parameter int V_ACTIVE     = 480,
  parameter int H_SCALE_LOG2 = 2,
  parameter int V_SCALE_LOG2 = 1,
  parameter int PX_W         = 9,
  parameter int PY_W         = 9,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int LOOKAHEAD    = 2
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic            ce,
  output logic            fetch_valid,
  output logic [PX_W-1:0] fetch_x,
  output logic [PY_W-1:0] fetch_y,
  output logic            new_pix,
  output logic            line_start,
  output logic            frame_start,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            de
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_OFS    = HW'(H_ACT_START);
  localparam logic [VW-1:0] V_OFS    = VW'(V_ACT_START);
  localparam logic [HW-1:0] H_MASK   = HW'((1 << H_SCALE_LOG2) - 1);
  localparam logic [HW:0]   H_SYNC_W = (HW+1)'(H_SYNC);
  localparam logic [HW:0]   H_ACT_LO = (HW+1)'(H_ACT_START);
  localparam logic [HW:0]   H_ACT_HI = (HW+1)'(H_ACT_START + H_ACTIVE);
  localparam logic [VW:0]   V_SYNC_W = (VW+1)'(V_SYNC);
  localparam logic [VW:0]   V_ACT_LO = (VW+1)'(V_ACT_START);
  localparam logic [VW:0]   V_ACT_HI = (VW+1)'(V_ACT_START + V_ACTIVE);

  vga_timing_gen_param_check #(
    .H_TOTAL     (H_TOTAL),
    .H_SYNC      (H_SYNC),
    .H_ACT_START (H_ACT_START),
    .H_ACTIVE    (H_ACTIVE),
    .V_TOTAL     (V_TOTAL),
    .V_ACT_START (V_ACT_START),
    .V_ACTIVE    (V_ACTIVE),
    .LOOKAHEAD   (LOOKAHEAD)
  ) u_param_check ();

  logic [HW-1:0]   hcnt_r;
  logic [VW-1:0]   vcnt_r;
  logic            hs_fetch_r;
  logic            vs_fetch_r;

  logic            h_act_s;
  logic            v_act_s;
  logic            act_s;
  logic [HW-1:0]   h_off_s;
  logic [VW-1:0]   v_off_s;
  logic [PX_W-1:0] x_next_s;
  logic [PY_W-1:0] y_next_s;
  logic            new_pix_s;
  logic            hs_next_s;
  logic            vs_next_s;

  // Raster counters: hcnt wraps each line, vcnt advances on the line wrap.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      hcnt_r <= {HW{1'b0}};
      vcnt_r <= {VW{1'b0}};
    end else if (ce) begin
      if (hcnt_r == H_LAST) begin
        hcnt_r <= {HW{1'b0}};
        vcnt_r <= (vcnt_r == V_LAST) ? {VW{1'b0}} : vcnt_r + 1'b1;
      end else begin
        hcnt_r <= hcnt_r + 1'b1;
      end
    end
  end

  // Next fetch-stage values decoded from the current counter position.
  always_comb begin
    h_act_s   = ({1'b0, hcnt_r} >= H_ACT_LO) && ({1'b0, hcnt_r} < H_ACT_HI);
    v_act_s   = ({1'b0, vcnt_r} >= V_ACT_LO) && ({1'b0, vcnt_r} < V_ACT_HI);
    act_s     = h_act_s && v_act_s;
    // Offsets wrap at counter width outside the active area; they are masked off there.
    h_off_s   = hcnt_r - H_OFS;
    v_off_s   = vcnt_r - V_OFS;
    x_next_s  = {PX_W{1'b0}};
    y_next_s  = {PY_W{1'b0}};
    new_pix_s = 1'b0;
    if (act_s) begin
      x_next_s  = PX_W'(h_off_s >> H_SCALE_LOG2);
      y_next_s  = PY_W'(v_off_s >> V_SCALE_LOG2);
      new_pix_s = ((h_off_s & H_MASK) == {HW{1'b0}});
    end else begin
      x_next_s  = {PX_W{1'b0}};
      y_next_s  = {PY_W{1'b0}};
      new_pix_s = 1'b0;
    end
    hs_next_s = ({1'b0, hcnt_r} < H_SYNC_W) ? HS_POL : ~HS_POL;
    vs_next_s = ({1'b0, vcnt_r} < V_SYNC_W) ? VS_POL : ~VS_POL;
  end

  // Fetch-stage registers, one ce-clock behind the counters.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      fetch_valid <= 1'b0;
      fetch_x     <= {PX_W{1'b0}};
      fetch_y     <= {PY_W{1'b0}};
      new_pix     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_fetch_r  <= ~HS_POL;
      vs_fetch_r  <= ~VS_POL;
    end else if (ce) begin
      fetch_valid <= act_s;
      fetch_x     <= x_next_s;
      fetch_y     <= y_next_s;
      new_pix     <= new_pix_s;
      line_start  <= (hcnt_r == {HW{1'b0}});
      frame_start <= (hcnt_r == {HW{1'b0}}) && (vcnt_r == {VW{1'b0}});
      hs_fetch_r  <= hs_next_s;
      vs_fetch_r  <= vs_next_s;
    end
  end

  if (LOOKAHEAD == 0) begin : g_no_pipe
    assign VGA_HS = hs_fetch_r;
    assign VGA_VS = vs_fetch_r;
    assign de     = fetch_valid;
  end else begin : g_pipe
    // Bit order per stage: {hsync, vsync, de}.
    logic [2:0] pipe_r [LOOKAHEAD];

    // Display-side delay line so sync/DE line up with memory read data.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
        for (int i = 0; i < LOOKAHEAD; i++) begin
          pipe_r[i] <= {~HS_POL, ~VS_POL, 1'b0};
        end
      end else if (ce) begin
        pipe_r[0] <= {hs_fetch_r, vs_fetch_r, fetch_valid};
        for (int i = 1; i < LOOKAHEAD; i++) begin
          pipe_r[i] <= pipe_r[i-1];
        end
      end
    end

    assign VGA_HS = pipe_r[LOOKAHEAD-1][2];
    assign VGA_VS = pipe_r[LOOKAHEAD-1][1];
    assign de     = pipe_r[LOOKAHEAD-1][0];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: instance A (default horizontal timing, short frame,
// LOOKAHEAD=2) and instance B (tiny raster, LOOKAHEAD=0, active-high syncs).

module tb_vga_timing_gen;

  typedef struct packed {
    logic       fv;
    logic [8:0] fx;
    logic [8:0] fy;
    logic       np;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ce;

  logic       a_fv, a_np, a_ls, a_fs, a_hs, a_vs, a_de;
  logic [8:0] a_fx, a_fy;
  logic       b_fv, b_np, b_ls, b_fs, b_hs, b_vs, b_de;
  logic [8:0] b_fx, b_fy;
  exp_t       obs_a, obs_b;

  assign obs_a = {a_fv, a_fx, a_fy, a_np, a_ls, a_fs, a_hs, a_vs, a_de};
  assign obs_b = {b_fv, b_fx, b_fy, b_np, b_ls, b_fs, b_hs, b_vs, b_de};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .V_TOTAL(8), .V_SYNC(2), .V_ACT_START(3), .V_ACTIVE(4), .LOOKAHEAD(2)
  ) dut_a (
    .CLOCK_50(clk), .RESET(rst), .ce(ce),
    .fetch_valid(a_fv), .fetch_x(a_fx), .fetch_y(a_fy), .new_pix(a_np),
    .line_start(a_ls), .frame_start(a_fs), .VGA_HS(a_hs), .VGA_VS(a_vs), .de(a_de)
  );

  vga_timing_gen #(
    .H_TOTAL(40), .H_SYNC(6), .H_ACT_START(9), .H_ACTIVE(24),
    .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(3), .V_ACTIVE(8),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(0)
  ) dut_b (
    .CLOCK_50(clk), .RESET(rst), .ce(ce),
    .fetch_valid(b_fv), .fetch_x(b_fx), .fetch_y(b_fy), .new_pix(b_np),
    .line_start(b_ls), .frame_start(b_fs), .VGA_HS(b_hs), .VGA_VS(b_vs), .de(b_de)
  );

  int   errs   = 0;
  int   checks = 0;
  int   hm [2];
  int   vm [2];
  int   lh [2];
  int   lv [2];
  exp_t stg [2];
  exp_t p0, p1;
  exp_t q_a [$];
  exp_t q_b [$];
  exp_t ea, eb;

  function automatic exp_t rst_val(input int d);
    exp_t e;
    e    = '0;
    e.hs = (d == 0) ? 1'b1 : 1'b0;
    e.vs = (d == 0) ? 1'b1 : 1'b0;
    return e;
  endfunction

  // Reference timing taken straight from the raster definition.
  function automatic exp_t fetch_of(input int d, input int hh, input int vv);
    exp_t e;
    int hsw, has, ha, vsw, vas, va, hk, vk;
    logic hp, vp;
    if (d == 0) begin
      hsw = 190; has = 285; ha = 1270; vsw = 2; vas = 3; va = 4; hk = 2; vk = 1; hp = 1'b0; vp = 1'b0;
    end else begin
      hsw = 6; has = 9; ha = 24; vsw = 2; vas = 3; va = 8; hk = 2; vk = 1; hp = 1'b1; vp = 1'b1;
    end
    e    = '0;
    e.fv = (hh >= has) && (hh < has + ha) && (vv >= vas) && (vv < vas + va);
    if (e.fv) begin
      e.fx = 9'((hh - has) >> hk);
      e.fy = 9'((vv - vas) >> vk);
      e.np = (((hh - has) % (1 << hk)) == 0);
    end
    e.ls = (hh == 0);
    e.fs = (hh == 0) && (vv == 0);
    e.hs = (hh < hsw) ? hp : ~hp;
    e.vs = (vv < vsw) ? vp : ~vp;
    e.de = e.fv;
    return e;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      hm[d] = 0; vm[d] = 0; lh[d] = -1; lv[d] = -1;
      stg[d] = rst_val(d);
    end
    p0 = rst_val(0);
    p1 = rst_val(0);
  endtask

  task automatic model_step();
    int ht, vt;
    p1 = p0;
    p0 = stg[0];
    for (int d = 0; d < 2; d++) begin
      ht = (d == 0) ? 1586 : 40;
      vt = (d == 0) ? 8 : 12;
      stg[d] = fetch_of(d, hm[d], vm[d]);
      lh[d] = hm[d];
      lv[d] = vm[d];
      if (hm[d] == ht - 1) begin
        hm[d] = 0;
        vm[d] = (vm[d] == vt - 1) ? 0 : vm[d] + 1;
      end else begin
        hm[d] = hm[d] + 1;
      end
    end
  endtask

  task automatic push_expect();
    exp_t a;
    a    = stg[0];
    a.hs = p1.hs;
    a.vs = p1.vs;
    a.de = p1.de;
    q_a.push_back(a);
    q_b.push_back(stg[1]);
  endtask

  // One clock of stimulus; expected outputs are queued for the caller to pop.
  task automatic cycle(input logic c);
    ce = c;
    @(posedge clk);
    if (rst) model_reset();
    else if (c) model_step();
    push_expect();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset(); push_expect();
    ea = q_a.pop_front(); eb = q_b.pop_front();
    checks++; if (obs_a !== ea) begin errs++; $display("FAIL reset_a got=%h exp=%h", obs_a, ea); end
    checks++; if (obs_b !== eb) begin errs++; $display("FAIL reset_b got=%h exp=%h", obs_b, eb); end
    checks++; if (b_hs !== 1'b0 || b_vs !== 1'b0) begin errs++; $display("FAIL reset_pol_b got=%b%b exp=00", b_hs, b_vs); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      checks++; if (obs_a !== ea) begin errs++; $display("FAIL idle_a got=%h exp=%h", obs_a, ea); end
      checks++; if (obs_b !== eb) begin errs++; $display("FAIL idle_b got=%h exp=%h", obs_b, eb); end
    end
    cycle(1'b1);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    checks++; if (obs_a !== ea) begin errs++; $display("FAIL first_a got=%h exp=%h", obs_a, ea); end
    checks++; if (obs_b !== eb) begin errs++; $display("FAIL first_b got=%h exp=%h", obs_b, eb); end
    checks++; if (a_fs !== 1'b1 || b_fs !== 1'b1) begin errs++; $display("FAIL first_fs got=%b%b exp=11", a_fs, b_fs); end
  endtask

  task automatic test_hsync();
    int a_low = 0;
    int b_high = 0;
    for (int i = 0; i < 1586; i++) begin
      cycle(1'b1);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      checks++; if (obs_a !== ea) begin errs++; $display("FAIL hs_a t=%0t got=%h exp=%h", $time, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errs++; $display("FAIL hs_b t=%0t got=%h exp=%h", $time, obs_b, eb); end
      if (a_hs == 1'b0) a_low++;
      if (i < 40 && b_hs == 1'b1) b_high++;
    end
    checks++; if (a_low != 190) begin errs++; $display("FAIL hs_low_a got=%0d exp=190", a_low); end
    checks++; if (b_high != 6) begin errs++; $display("FAIL hs_high_b got=%0d exp=6", b_high); end
  endtask

  task automatic test_scaling();
    int n = 0;
    while (!(lv[0] == 6 && lh[0] == 1585) && n < 15000) begin
      cycle(1'b1); n++;
      ea = q_a.pop_front(); eb = q_b.pop_front();
      checks++; if (obs_a !== ea) begin errs++; $display("FAIL sc_a t=%0t got=%h exp=%h", $time, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errs++; $display("FAIL sc_b t=%0t got=%h exp=%h", $time, obs_b, eb); end
      if (lv[0] == 3 && lh[0] >= 285 && lh[0] <= 288) begin
        checks++;
        if (a_fx !== 9'd0 || a_np !== (lh[0] == 285)) begin
          errs++; $display("FAIL sc_x0 h=%0d got=%0d/%b exp=0/%b", lh[0], a_fx, a_np, lh[0] == 285);
        end
      end
      if (lv[0] == 3 && lh[0] == 289) begin
        checks++; if (a_fx !== 9'd1 || a_np !== 1'b1) begin errs++; $display("FAIL sc_x1 got=%0d/%b exp=1/1", a_fx, a_np); end
      end
      if (lv[0] == 3 && lh[0] == 1554) begin
        checks++; if (a_fx !== 9'd317) begin errs++; $display("FAIL sc_x317 got=%0d exp=317", a_fx); end
      end
      if (lh[0] == 600 && lv[0] >= 2) begin
        checks++;
        if (a_fv !== (lv[0] >= 3) || a_fy !== ((lv[0] >= 5) ? 9'd1 : 9'd0)) begin
          errs++; $display("FAIL sc_y v=%0d got=%b/%0d", lv[0], a_fv, a_fy);
        end
      end
    end
    checks++; if (n >= 15000) begin errs++; $display("FAIL sc_timeout got=%0d exp<15000", n); end
  endtask

  task automatic test_frame();
    int n = 0;
    int per = 0;
    int vs_low = 0;
    int fv_at = -1;
    int de_at = -1;
    int b_misalign = 0;
    logic pfv = 1'b1;
    logic pde = 1'b1;
    while (a_fs !== 1'b1 && n < 14000) begin
      cycle(1'b1); n++;
      ea = q_a.pop_front(); eb = q_b.pop_front();
      checks++; if (obs_a !== ea) begin errs++; $display("FAIL fr_a t=%0t got=%h exp=%h", $time, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errs++; $display("FAIL fr_b t=%0t got=%h exp=%h", $time, obs_b, eb); end
    end
    do begin
      cycle(1'b1); per++;
      ea = q_a.pop_front(); eb = q_b.pop_front();
      checks++; if (obs_a !== ea) begin errs++; $display("FAIL fr_a t=%0t got=%h exp=%h", $time, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errs++; $display("FAIL fr_b t=%0t got=%h exp=%h", $time, obs_b, eb); end
      if (a_vs == 1'b0) vs_low++;
      if (fv_at < 0 && a_fv && !pfv) fv_at = per;
      if (de_at < 0 && a_de && !pde) de_at = per;
      pfv = a_fv; pde = a_de;
      if (b_fv !== b_de) b_misalign++;
    end while (a_fs !== 1'b1 && per < 14000);
    checks++; if (per != 12688) begin errs++; $display("FAIL fs_period got=%0d exp=12688", per); end
    checks++; if (vs_low != 3172) begin errs++; $display("FAIL vs_low got=%0d exp=3172", vs_low); end
    checks++; if (fv_at < 0 || de_at - fv_at != 2) begin errs++; $display("FAIL de_lag_a got=%0d exp=2", de_at - fv_at); end
    checks++; if (b_misalign != 0) begin errs++; $display("FAIL de_align_b got=%0d exp=0", b_misalign); end
  endtask

  task automatic test_ce_toggle();
    int first = -1;
    int second = -1;
    logic pls = 1'b1;
    for (int i = 0; i < 240; i++) begin
      cycle((i % 2) == 0);
      ea = q_a.pop_front(); eb = q_b.pop_front();
      checks++; if (obs_a !== ea) begin errs++; $display("FAIL ce_a t=%0t got=%h exp=%h", $time, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errs++; $display("FAIL ce_b t=%0t got=%h exp=%h", $time, obs_b, eb); end
      if (b_ls && !pls) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      pls = b_ls;
    end
    checks++; if (first < 0 || second - first != 80) begin errs++; $display("FAIL ce_period got=%0d exp=80", second - first); end
  endtask

  task automatic test_reset_midline();
    int n = 0;
    while (!(lh[0] == 700 && lv[0] == 5) && n < 14000) begin
      cycle(1'b1); n++;
      ea = q_a.pop_front(); eb = q_b.pop_front();
      checks++; if (obs_a !== ea) begin errs++; $display("FAIL mr_a t=%0t got=%h exp=%h", $time, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errs++; $display("FAIL mr_b t=%0t got=%h exp=%h", $time, obs_b, eb); end
    end
    checks++; if (a_fv !== 1'b1) begin errs++; $display("FAIL mr_pre_fv got=%b exp=1", a_fv); end
    #2 rst = 1'b1;
    #1;
    model_reset(); push_expect();
    ea = q_a.pop_front(); eb = q_b.pop_front();
    checks++; if (obs_a !== ea) begin errs++; $display("FAIL mr_async_a got=%h exp=%h", obs_a, ea); end
    checks++; if (obs_b !== eb) begin errs++; $display("FAIL mr_async_b got=%h exp=%h", obs_b, eb); end
    checks++; if (a_fv !== 1'b0 || a_de !== 1'b0 || a_hs !== 1'b1) begin errs++; $display("FAIL mr_inactive got=%b%b%b exp=001", a_fv, a_de, a_hs); end
    cycle(1'b1);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    checks++; if (obs_a !== ea) begin errs++; $display("FAIL mr_hold_a got=%h exp=%h", obs_a, ea); end
    rst = 1'b0;
    cycle(1'b1);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    checks++; if (obs_a !== ea) begin errs++; $display("FAIL mr_rel_a got=%h exp=%h", obs_a, ea); end
    checks++; if (obs_b !== eb) begin errs++; $display("FAIL mr_rel_b got=%h exp=%h", obs_b, eb); end
    checks++; if (a_fs !== 1'b1) begin errs++; $display("FAIL mr_fs got=%b exp=1", a_fs); end
    cycle(1'b1);
    ea = q_a.pop_front(); eb = q_b.pop_front();
    checks++; if (a_fs !== 1'b0 || obs_a !== ea) begin errs++; $display("FAIL mr_fs_pulse got=%h exp=%h", obs_a, ea); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_scaling();
    test_frame();
    test_ce_toggle();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
